// File: rtl/nnrv_if_pkg.sv
// ============================================================================
// Module   : nnrv_if_pkg
// Brief    : Shared constants and helpers for the prefetching fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package nnrv_if_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int FETCH_BYTES = 8;

    // Clears the byte-offset bits inside one fetch doubleword.
    localparam logic [63:0] FETCH_ALIGN_MASK = ~64'(FETCH_BYTES - 1);

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nnrv_if_queue.sv
// ============================================================================
// Module   : nnrv_if_queue
// Brief    : In-order instruction queue, two pushes and one pop per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nnrv_if_queue
    import nnrv_if_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_flush,
    input  logic                          i_push0,
    input  logic [WIDTH-1:0]              i_data0,
    input  logic                          i_push1,
    input  logic [WIDTH-1:0]              i_data1,
    input  logic                          i_pop,
    output logic                          o_valid,
    output logic [WIDTH-1:0]              o_head,
    output logic [level_width(DEPTH)-1:0] o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = level_width(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_count;
    logic [c_lvl_w-1:0] w_n_push;
    logic               w_pop;

    // i_push1 is only ever raised together with i_push0 (slot order is fixed).
    always_comb begin
        w_n_push = c_lvl_w'(i_push0) + c_lvl_w'(i_push1);
        w_pop    = i_pop && (r_count != '0);
        o_valid  = (r_count != '0);
        o_head   = o_valid ? r_mem[r_rd_ptr] : '0;
        o_count  = r_count;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(w_n_push);
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(w_pop);
            r_count  <= r_count + w_n_push - c_lvl_w'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push0) begin
            r_mem[r_wr_ptr] <= i_data0;
        end
        if (i_push1) begin
            r_mem[r_wr_ptr + c_ptr_w'(1)] <= i_data1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/nnrv_if_pf.sv
// ============================================================================
// Module   : nnrv_if_pf
// Brief    : Prefetching instruction fetch: fetch PC, in-flight read, credits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nnrv_if_pf
    import nnrv_if_pkg::*;
#(
    parameter int               DATA_WIDTH  = 64,
    parameter int               INSTR_WIDTH = 32,
    parameter int               MASK_WIDTH  = DATA_WIDTH >> 3,
    parameter int               XLEN        = 64,
    parameter int               FIFO_DEPTH  = 4,
    parameter logic [XLEN-1:0]  RESET_PC    = '0
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    output logic [XLEN-1:0]                    o_ram_rd_addr,
    output logic                               o_ram_rd_en,
    output logic [MASK_WIDTH-1:0]              o_ram_rd_mask,
    input  logic                               i_ram_rd_gnt,
    input  logic [DATA_WIDTH-1:0]              i_ram_rd_data,
    output logic                               o_id_valid,
    output logic [INSTR_WIDTH-1:0]             o_id_instr,
    output logic [XLEN-1:0]                    o_id_cur_pc,
    input  logic                               i_id_ready,
    input  logic                               i_id_jmp_stall,
    input  logic [XLEN-1:0]                    i_id_jmp_pc,
    output logic [level_width(FIFO_DEPTH)-1:0] o_if_level
);

    localparam int              c_lvl_w      = level_width(FIFO_DEPTH);
    localparam int              c_need_w     = c_lvl_w + 1;
    localparam int              c_entry_w    = INSTR_WIDTH + XLEN;
    localparam logic [XLEN-1:0] c_align_mask = FETCH_ALIGN_MASK[XLEN-1:0];
    localparam logic [XLEN-1:0] c_fetch_step = XLEN'(FETCH_BYTES);
    localparam logic [XLEN-1:0] c_instr_step = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] c_jmp_mask   = ~XLEN'(INSTR_BYTES - 1);

    logic [XLEN-1:0]        r_fetch_pc;
    logic [XLEN-1:0]        r_inflight_pc;
    logic                   r_inflight;
    logic                   r_rst_q;

    logic                   w_push0;
    logic                   w_push1;
    logic                   w_grant;
    logic [INSTR_WIDTH-1:0] w_lo;
    logic [INSTR_WIDTH-1:0] w_hi;
    logic [c_entry_w-1:0]   w_data0;
    logic [c_entry_w-1:0]   w_data1;
    logic [c_entry_w-1:0]   w_head;
    logic [1:0]             w_resp_n;
    logic [c_lvl_w-1:0]     w_count;
    logic [c_need_w-1:0]    w_need;

    always_comb begin
        w_lo     = i_ram_rd_data[INSTR_WIDTH-1:0];
        w_hi     = i_ram_rd_data[DATA_WIDTH-1:INSTR_WIDTH];
        // A jump in the response cycle kills the returning data.
        w_push0  = r_inflight && !i_id_jmp_stall;
        w_push1  = w_push0 && !r_inflight_pc[2];
        w_data0  = r_inflight_pc[2] ? {w_hi, r_inflight_pc} : {w_lo, r_inflight_pc};
        w_data1  = {w_hi, r_inflight_pc + c_instr_step};
        w_resp_n = {1'b0, w_push0} + {1'b0, w_push1};

        // Dequeue is deliberately not credited, so a grant can never overflow.
        w_need   = {1'b0, w_count} + c_need_w'(w_resp_n) + c_need_w'(2);
        o_ram_rd_en   = !i_rst && !r_rst_q && !i_id_jmp_stall &&
                        (w_need <= c_need_w'(FIFO_DEPTH));
        o_ram_rd_addr = r_fetch_pc & c_align_mask;
        o_ram_rd_mask = '1;
        w_grant       = o_ram_rd_en && i_ram_rd_gnt;

        o_id_instr  = w_head[c_entry_w-1:XLEN];
        o_id_cur_pc = w_head[XLEN-1:0];
        o_if_level  = w_count;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_rst_q       <= 1'b1;
        end else begin
            r_rst_q <= 1'b0;
            if (i_id_jmp_stall) begin
                r_fetch_pc <= i_id_jmp_pc & c_jmp_mask;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_grant;
                if (w_grant) begin
                    r_inflight_pc <= r_fetch_pc;
                    r_fetch_pc    <= (r_fetch_pc & c_align_mask) + c_fetch_step;
                end
            end
        end
    end

    nnrv_if_queue #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_id_jmp_stall),
        .i_push0 (w_push0),
        .i_data0 (w_data0),
        .i_push1 (w_push1),
        .i_data1 (w_data1),
        .i_pop   (i_id_ready),
        .o_valid (o_id_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

endmodule

`default_nettype wire
